// File: rtl/daq_frame_buffer.sv
// Elastic frame buffer between the DAQ readout formatter and the TMB link.
// Whole frames are stored in a circular RAM and replayed with valid/ready; frames that do not fit are dropped.
module daq_frame_buffer #(
  parameter int ADDR_W = 11,
  parameter int LQ_AW  = 3
) (
  input  logic             clk,
  input  logic             hard_rst,
  input  logic [18:0]      daqp,
  output logic [17:0]      dout,
  output logic             dout_valid,
  output logic             dout_last,
  input  logic             dout_ready,
  output logic [LQ_AW:0]   frames_pending,
  output logic [7:0]       drop_count,
  output logic             buf_full
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int LQ_D  = 1 << LQ_AW;
  localparam logic [PW-1:0]    PTR_ONE    = PW'(1'b1);
  localparam logic [PW-1:0]    PTR_TWO    = PW'(2'd2);
  localparam logic [PW-1:0]    PTR_DEPTH  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LQ_AW-1:0] LQ_PTR_ONE = LQ_AW'(1'b1);
  localparam logic [LQ_AW:0]   LQ_ONE     = {{LQ_AW{1'b0}}, 1'b1};
  localparam logic [LQ_AW:0]   LQ_FULL    = {1'b1, {LQ_AW{1'b0}}};

  typedef enum logic [1:0] {WIDLE = 2'd0, WFRAME = 2'd1, WDROP = 2'd2} wstate_t;
  typedef enum logic [1:0] {RIDLE = 2'd0, RLOAD = 2'd1, RSEND = 2'd2} rstate_t;

  wstate_t w_state_r, w_state_s;
  rstate_t r_state_r, r_state_s;

  logic [PW-1:0] wr_ptr_r, wr_ptr_s, fs_ptr_r, fs_ptr_s, len_r, len_s;
  logic [PW-1:0] rd_ptr_r, rd_ptr_s, rem_r, rem_s;
  logic [PW-1:0] rd_ptr_p1_s, rd_ptr_p2_s;
  logic          we_s, commit_s, drop_s, pop_s, done_s;
  logic          valid_in_s, ram_full_s, lq_full_s;
  logic [ADDR_W-1:0] raddr_s;

  logic [17:0] mem [0:DEPTH-1];
  logic [17:0] ram_q_r;

  logic [PW-1:0]    lq_mem_r [0:LQ_D-1];
  logic [LQ_AW-1:0] lq_wp_r, lq_rp_r;
  logic [LQ_AW:0]   lq_cnt_r;

  logic [17:0]    dout_r, dout_s;
  logic           dout_valid_r, dout_valid_s, dout_last_r, dout_last_s;
  logic [LQ_AW:0] frames_pending_r;
  logic [7:0]     drop_count_r;
  logic           buf_full_r;

  assign valid_in_s  = ~daqp[18];
  assign ram_full_s  = ((wr_ptr_r - rd_ptr_r) == PTR_DEPTH);
  // Pending (not queued) frames gate new starts, so a frame stalled in readout still holds a slot.
  assign lq_full_s   = (frames_pending_r == LQ_FULL);
  assign rd_ptr_p1_s = rd_ptr_r + PTR_ONE;
  assign rd_ptr_p2_s = rd_ptr_r + PTR_TWO;

  // Write FSM: capture, abort and commit of frames
  always_comb begin
    w_state_s = w_state_r;
    wr_ptr_s  = wr_ptr_r;
    fs_ptr_s  = fs_ptr_r;
    len_s     = len_r;
    we_s      = 1'b0;
    commit_s  = 1'b0;
    drop_s    = 1'b0;
    case (w_state_r)
      WIDLE: begin
        if (valid_in_s) begin
          if (lq_full_s || ram_full_s) begin
            drop_s    = 1'b1;
            w_state_s = WDROP;
          end else begin
            we_s      = 1'b1;
            fs_ptr_s  = wr_ptr_r;
            wr_ptr_s  = wr_ptr_r + PTR_ONE;
            len_s     = PTR_ONE;
            w_state_s = WFRAME;
          end
        end else begin
          w_state_s = WIDLE;
        end
      end
      WFRAME: begin
        if (valid_in_s) begin
          if (ram_full_s) begin
            wr_ptr_s  = fs_ptr_r;
            drop_s    = 1'b1;
            w_state_s = WDROP;
          end else begin
            we_s     = 1'b1;
            wr_ptr_s = wr_ptr_r + PTR_ONE;
            len_s    = len_r + PTR_ONE;
          end
        end else begin
          commit_s  = 1'b1;
          w_state_s = WIDLE;
        end
      end
      WDROP: begin
        if (valid_in_s) begin
          w_state_s = WDROP;
        end else begin
          w_state_s = WIDLE;
        end
      end
      default: w_state_s = WIDLE;
    endcase
  end

  // Read FSM: the RAM always pre-reads the word after the one on dout, so accepts need no bubble
  always_comb begin
    r_state_s    = r_state_r;
    rd_ptr_s     = rd_ptr_r;
    rem_s        = rem_r;
    pop_s        = 1'b0;
    done_s       = 1'b0;
    raddr_s      = rd_ptr_r[ADDR_W-1:0];
    dout_s       = dout_r;
    dout_valid_s = dout_valid_r;
    dout_last_s  = dout_last_r;
    case (r_state_r)
      RIDLE: begin
        if (lq_cnt_r != {(LQ_AW+1){1'b0}}) begin
          pop_s     = 1'b1;
          rem_s     = lq_mem_r[lq_rp_r];
          r_state_s = RLOAD;
        end else begin
          r_state_s = RIDLE;
        end
      end
      RLOAD: begin
        raddr_s      = rd_ptr_p1_s[ADDR_W-1:0];
        dout_s       = ram_q_r;
        dout_valid_s = 1'b1;
        dout_last_s  = (rem_r == PTR_ONE);
        r_state_s    = RSEND;
      end
      RSEND: begin
        raddr_s = rd_ptr_p1_s[ADDR_W-1:0];
        if (dout_valid_r && dout_ready) begin
          rd_ptr_s = rd_ptr_p1_s;
          rem_s    = rem_r - PTR_ONE;
          if (rem_r == PTR_ONE) begin
            dout_valid_s = 1'b0;
            dout_last_s  = 1'b0;
            done_s       = 1'b1;
            r_state_s    = RIDLE;
          end else begin
            raddr_s     = rd_ptr_p2_s[ADDR_W-1:0];
            dout_s      = ram_q_r;
            dout_last_s = (rem_r == PTR_TWO);
          end
        end else begin
          r_state_s = RSEND;
        end
      end
      default: r_state_s = RIDLE;
    endcase
  end

  // Frame storage RAM with registered read port
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[wr_ptr_r[ADDR_W-1:0]] <= daqp[17:0];
    end
    ram_q_r <= mem[raddr_s];
  end

  // State, pointers, length queue and output registers
  always_ff @(posedge clk or negedge hard_rst) begin
    if (!hard_rst) begin
      w_state_r        <= WIDLE;
      r_state_r        <= RIDLE;
      wr_ptr_r         <= {PW{1'b0}};
      fs_ptr_r         <= {PW{1'b0}};
      len_r            <= {PW{1'b0}};
      rd_ptr_r         <= {PW{1'b0}};
      rem_r            <= {PW{1'b0}};
      lq_wp_r          <= {LQ_AW{1'b0}};
      lq_rp_r          <= {LQ_AW{1'b0}};
      lq_cnt_r         <= {(LQ_AW+1){1'b0}};
      for (int i = 0; i < LQ_D; i++) lq_mem_r[i] <= {PW{1'b0}};
      dout_r           <= 18'd0;
      dout_valid_r     <= 1'b0;
      dout_last_r      <= 1'b0;
      frames_pending_r <= {(LQ_AW+1){1'b0}};
      drop_count_r     <= 8'd0;
      buf_full_r       <= 1'b0;
    end else begin
      w_state_r    <= w_state_s;
      r_state_r    <= r_state_s;
      wr_ptr_r     <= wr_ptr_s;
      fs_ptr_r     <= fs_ptr_s;
      len_r        <= len_s;
      rd_ptr_r     <= rd_ptr_s;
      rem_r        <= rem_s;
      dout_r       <= dout_s;
      dout_valid_r <= dout_valid_s;
      dout_last_r  <= dout_last_s;
      buf_full_r   <= ((wr_ptr_s - rd_ptr_s) == PTR_DEPTH);
      if (commit_s) begin
        lq_mem_r[lq_wp_r] <= len_r;
        lq_wp_r           <= lq_wp_r + LQ_PTR_ONE;
      end
      if (pop_s) begin
        lq_rp_r <= lq_rp_r + LQ_PTR_ONE;
      end
      case ({commit_s, pop_s})
        2'b10:   lq_cnt_r <= lq_cnt_r + LQ_ONE;
        2'b01:   lq_cnt_r <= lq_cnt_r - LQ_ONE;
        default: lq_cnt_r <= lq_cnt_r;
      endcase
      case ({commit_s, done_s})
        2'b10:   frames_pending_r <= frames_pending_r + LQ_ONE;
        2'b01:   frames_pending_r <= frames_pending_r - LQ_ONE;
        default: frames_pending_r <= frames_pending_r;
      endcase
      if (drop_s && (drop_count_r != 8'hFF)) begin
        drop_count_r <= drop_count_r + 8'd1;
      end
    end
  end

  assign dout           = dout_r;
  assign dout_valid     = dout_valid_r;
  assign dout_last      = dout_last_r;
  assign frames_pending = frames_pending_r;
  assign drop_count     = drop_count_r;
  assign buf_full       = buf_full_r;

endmodule

// File: tb/tb_daq_frame_buffer.sv
// Directed self-checking bench for daq_frame_buffer: a default-size instance plus an ADDR_W=4 instance for overflow.
module tb_daq_frame_buffer;

  localparam logic [18:0] IDLE = 19'h40000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hard_rst;
  logic [18:0] daqp, daqp_b;
  logic        dout_ready, dout_ready_b;
  logic [17:0] dout, dout_b;
  logic        dout_valid, dout_valid_b, dout_last, dout_last_b;
  logic [3:0]  frames_pending, fp_b;
  logic [7:0]  drop_count, drop_count_b;
  logic        buf_full, buf_full_b;

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];

  daq_frame_buffer dut (
    .clk(clk), .hard_rst(hard_rst), .daqp(daqp), .dout(dout), .dout_valid(dout_valid),
    .dout_last(dout_last), .dout_ready(dout_ready), .frames_pending(frames_pending),
    .drop_count(drop_count), .buf_full(buf_full)
  );

  daq_frame_buffer #(.ADDR_W(4), .LQ_AW(3)) dut_b (
    .clk(clk), .hard_rst(hard_rst), .daqp(daqp_b), .dout(dout_b), .dout_valid(dout_valid_b),
    .dout_last(dout_last_b), .dout_ready(dout_ready_b), .frames_pending(fp_b),
    .drop_count(drop_count_b), .buf_full(buf_full_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [17:0] w);
    daqp = {1'b0, w};
    @(negedge clk);
  endtask

  task automatic drv_b(input logic [17:0] w);
    daqp_b = {1'b0, w};
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    daqp = IDLE;
    daqp_b = IDLE;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input bit sel);
    int k = 0;
    while (!(sel ? dout_valid_b : dout_valid) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("wait_valid", 32'(sel ? dout_valid_b : dout_valid), 32'd1);
  endtask

  // Receive n words with ready held high; expects back-to-back words from exp_q
  task automatic recv(input bit sel, input int n, input logic [3:0] fp_after);
    logic [17:0] e;
    wait_valid(sel);
    if (sel) dout_ready_b = 1'b1; else dout_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("word%0d", i), 32'(sel ? dout_b : dout), 32'(e));
      chk($sformatf("valid%0d", i), 32'(sel ? dout_valid_b : dout_valid), 32'd1);
      chk($sformatf("last%0d", i), 32'(sel ? dout_last_b : dout_last), 32'(i == n - 1));
      @(negedge clk);
    end
    chk("valid_after_frame", 32'(sel ? dout_valid_b : dout_valid), 32'd0);
    chk("pending_after_frame", 32'(sel ? fp_b : frames_pending), 32'(fp_after));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [17:0] t1 [0:4];
    t1[0] = 18'h1DB0A; t1[1] = 18'h0D123; t1[2] = 18'h00001; t1[3] = 18'h00002; t1[4] = 18'h3A0FF;

    hard_rst = 1'b0; daqp = IDLE; daqp_b = IDLE; dout_ready = 1'b0; dout_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_last", 32'(dout_last), 32'd0);
    chk("rst_pending", 32'(frames_pending), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_full", 32'(buf_full), 32'd0);
    hard_rst = 1'b1;
    @(negedge clk);

    // 5-word frame, ready high: commit latency and gapless replay
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(t1[i]);
      drv(t1[i]);
    end
    idle(1);
    chk("t1_pending_commit", 32'(frames_pending), 32'd1);
    chk("t1_valid_m0", 32'(dout_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_m1", 32'(dout_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_m2", 32'(dout_valid), 32'd1);
    recv(1'b0, 5, 4'd0);

    // 1-word frame, one idle, then a 3-word frame
    dout_ready = 1'b0;
    exp_q.push_back(18'h2AAAA); drv(18'h2AAAA);
    idle(1);
    exp_q.push_back(18'h11111); drv(18'h11111);
    exp_q.push_back(18'h22222); drv(18'h22222);
    exp_q.push_back(18'h33333); drv(18'h33333);
    idle(1);
    chk("t2_pending", 32'(frames_pending), 32'd2);
    recv(1'b0, 1, 4'd1);
    recv(1'b0, 3, 4'd0);

    // Stall pattern 1,0,0,1 during a 4-word frame
    dout_ready = 1'b0;
    drv(18'h00A0A); drv(18'h00B0B); drv(18'h00C0C); drv(18'h00D0D);
    idle(1);
    wait_valid(1'b0);
    chk("t3_w0", 32'(dout), 32'h00A0A);
    dout_ready = 1'b1; @(negedge clk);
    chk("t3_w1", 32'(dout), 32'h00B0B);
    dout_ready = 1'b0; @(negedge clk);
    chk("t3_hold1", 32'(dout), 32'h00B0B);
    chk("t3_hold1_last", 32'(dout_last), 32'd0);
    @(negedge clk);
    chk("t3_hold2", 32'(dout), 32'h00B0B);
    chk("t3_hold2_valid", 32'(dout_valid), 32'd1);
    dout_ready = 1'b1; @(negedge clk);
    exp_q.push_back(18'h00C0C);
    exp_q.push_back(18'h00D0D);
    recv(1'b0, 2, 4'd0);

    // ADDR_W=4: 20-word frame overflows and is dropped, then a 10-word frame passes
    dout_ready_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drv_b(18'(32'h100 + i));
      if (i == 15) chk("t4_buf_full", 32'(buf_full_b), 32'd1);
    end
    idle(1);
    chk("t4_drop", 32'(drop_count_b), 32'd1);
    chk("t4_pending", 32'(fp_b), 32'd0);
    chk("t4_full_cleared", 32'(buf_full_b), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      if (dout_valid_b) seen = 1'b1;
      @(negedge clk);
    end
    chk("t4_no_output", 32'(seen), 32'd0);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(18'(32'h200 + i));
      drv_b(18'(32'h200 + i));
    end
    idle(1);
    recv(1'b1, 10, 4'd0);
    chk("t4_drop_after", 32'(drop_count_b), 32'd1);

    // Nine 3-word frames with ready low: eight held, ninth dropped
    dout_ready = 1'b0;
    for (int f = 0; f < 9; f++) begin
      for (int w = 0; w < 3; w++) begin
        if (f < 8) exp_q.push_back(18'(32'h3000 + f * 16 + w));
        drv(18'(32'h3000 + f * 16 + w));
      end
      idle(1);
    end
    chk("t5_pending", 32'(frames_pending), 32'd8);
    chk("t5_drop", 32'(drop_count), 32'd1);
    for (int f = 0; f < 8; f++) begin
      recv(1'b0, 3, 4'(7 - f));
    end

    // Reset mid-readout and mid-frame, then a clean frame
    dout_ready = 1'b0;
    drv(18'h03F00); drv(18'h03F01); drv(18'h03F02);
    idle(1);
    wait_valid(1'b0);
    drv(18'h12345); drv(18'h12346);
    hard_rst = 1'b0;
    daqp = IDLE;
    #1;
    chk("t6_rst_dout", 32'(dout), 32'd0);
    chk("t6_rst_valid", 32'(dout_valid), 32'd0);
    chk("t6_rst_last", 32'(dout_last), 32'd0);
    chk("t6_rst_pending", 32'(frames_pending), 32'd0);
    chk("t6_rst_drop", 32'(drop_count), 32'd0);
    chk("t6_rst_full", 32'(buf_full), 32'd0);
    @(negedge clk);
    hard_rst = 1'b1;
    @(negedge clk);
    dout_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(18'h0F0F0); drv(18'h0F0F0);
    exp_q.push_back(18'h0E0E0); drv(18'h0E0E0);
    exp_q.push_back(18'h0D0D0); drv(18'h0D0D0);
    idle(1);
    recv(1'b0, 3, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
